// File: rtl/dram_window_bridge.sv
// Upstream window decoder for the DRAM path: remaps in-window requests onto
// the AXI bridge port, answers the rest locally, and returns responses in order.
module dram_window_bridge #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int MaxOutstanding = 4,
  parameter logic [AddrWidth-1:0] WindowBase = 32'h4000_0000,
  parameter logic [AddrWidth-1:0] WindowSize = 32'h1000_0000,
  parameter logic [AddrWidth-1:0] RemapBase = 32'h0000_0000,
  parameter logic [DataWidth-1:0] ErrorRdata = 32'hBADC_AB1E
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   slv_req_i,
  input  logic [AddrWidth-1:0]   slv_addr_i,
  input  logic                   slv_we_i,
  input  logic [DataWidth/8-1:0] slv_be_i,
  input  logic [DataWidth-1:0]   slv_wdata_i,
  output logic                   slv_gnt_o,
  output logic                   slv_rvalid_o,
  output logic [DataWidth-1:0]   slv_rdata_o,
  output logic                   slv_err_o,
  output logic                   mem_req_o,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic                   mem_we_o,
  output logic [DataWidth/8-1:0] mem_be_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rsp_valid_i,
  input  logic [DataWidth-1:0]   mem_rsp_rdata_i,
  input  logic                   mem_rsp_error_i
);

  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);

  function automatic logic [PtrW-1:0] inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  logic [AddrWidth-1:0] offset;
  logic in_win, slot, grant;

  logic ord_local [MaxOutstanding];
  logic ord_we [MaxOutstanding];
  logic [PtrW-1:0] ord_wptr, ord_rptr;
  logic [CntW-1:0] ord_count;

  logic [DataWidth-1:0] rsp_rdata [MaxOutstanding];
  logic rsp_err [MaxOutstanding];
  logic [PtrW-1:0] rsp_wptr, rsp_rptr;
  logic [CntW-1:0] rsp_count;

  // forwarded requests still waiting for their downstream response
  logic [CntW-1:0] fwd_cnt;

  logic rsp_ok, ord_pop, rsp_pop, rsp_push, bypass;
  logic sel_valid, sel_err;
  logic [DataWidth-1:0] sel_rdata;

  logic rvalid_q, err_q;
  logic [DataWidth-1:0] rdata_q;

  assign offset = slv_addr_i - WindowBase;
  assign in_win = offset < WindowSize;
  assign slot = ord_count < MaxCnt;
  assign grant = slv_req_i & slot & (in_win ? mem_gnt_i : 1'b1);

  assign slv_gnt_o = grant;
  assign mem_req_o = slv_req_i & in_win & slot;
  assign mem_addr_o = RemapBase + offset;
  assign mem_we_o = slv_we_i;
  assign mem_be_o = slv_be_i;
  assign mem_wdata_o = slv_wdata_i;

  assign rsp_ok = mem_rsp_valid_i & (fwd_cnt != '0);

  always_comb begin
    ord_pop = 1'b0;
    rsp_pop = 1'b0;
    bypass = 1'b0;
    sel_valid = 1'b0;
    sel_err = 1'b0;
    sel_rdata = '0;
    if (ord_count != '0) begin
      if (ord_local[ord_rptr]) begin
        sel_valid = 1'b1;
        sel_err = 1'b1;
        sel_rdata = ord_we[ord_rptr] ? '0 : ErrorRdata;
        ord_pop = 1'b1;
      end else if (rsp_count != '0) begin
        sel_valid = 1'b1;
        sel_err = rsp_err[rsp_rptr];
        sel_rdata = rsp_rdata[rsp_rptr];
        rsp_pop = 1'b1;
        ord_pop = 1'b1;
      end else if (rsp_ok) begin
        sel_valid = 1'b1;
        sel_err = mem_rsp_error_i;
        sel_rdata = mem_rsp_rdata_i;
        bypass = 1'b1;
        ord_pop = 1'b1;
      end
    end
  end

  assign rsp_push = rsp_ok & ~bypass;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ord_wptr <= '0;
      ord_rptr <= '0;
      ord_count <= '0;
      rsp_wptr <= '0;
      rsp_rptr <= '0;
      rsp_count <= '0;
      fwd_cnt <= '0;
      rvalid_q <= 1'b0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (grant) ord_wptr <= inc(ord_wptr);
      if (ord_pop) ord_rptr <= inc(ord_rptr);
      ord_count <= ord_count + CntW'(grant) - CntW'(ord_pop);
      if (rsp_push) rsp_wptr <= inc(rsp_wptr);
      if (rsp_pop) rsp_rptr <= inc(rsp_rptr);
      rsp_count <= rsp_count + CntW'(rsp_push) - CntW'(rsp_pop);
      fwd_cnt <= fwd_cnt + CntW'(grant & in_win) - CntW'(rsp_ok);
      rvalid_q <= sel_valid;
      rdata_q <= sel_rdata;
      err_q <= sel_err;
    end
  end

  always_ff @(posedge clk_i) begin
    if (grant) begin
      ord_local[ord_wptr] <= ~in_win;
      ord_we[ord_wptr] <= slv_we_i;
    end
    if (rsp_push) begin
      rsp_rdata[rsp_wptr] <= mem_rsp_rdata_i;
      rsp_err[rsp_wptr] <= mem_rsp_error_i;
    end
  end

  // unsolicited downstream responses are dropped
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(mem_rsp_valid_i && fwd_cnt == '0))
        else $error("unsolicited downstream response");
    end
  end

  assign slv_rvalid_o = rvalid_q;
  assign slv_rdata_o = rdata_q;
  assign slv_err_o = err_q;

endmodule

// File: tb/tb_dram_window_bridge.sv
// Directed bench for dram_window_bridge: decode, remap, ordering,
// outstanding limit, error pass-through and reset.
module tb_dram_window_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        slv_req_i;
  logic [31:0] slv_addr_i;
  logic        slv_we_i;
  logic [3:0]  slv_be_i;
  logic [31:0] slv_wdata_i;
  logic        slv_gnt_o;
  logic        slv_rvalid_o;
  logic [31:0] slv_rdata_o;
  logic        slv_err_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rsp_valid_i;
  logic [31:0] mem_rsp_rdata_i;
  logic        mem_rsp_error_i;

  int n_vec = 0;
  int n_bad = 0;

  dram_window_bridge dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .slv_req_i(slv_req_i),
    .slv_addr_i(slv_addr_i),
    .slv_we_i(slv_we_i),
    .slv_be_i(slv_be_i),
    .slv_wdata_i(slv_wdata_i),
    .slv_gnt_o(slv_gnt_o),
    .slv_rvalid_o(slv_rvalid_o),
    .slv_rdata_o(slv_rdata_o),
    .slv_err_o(slv_err_o),
    .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i),
    .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_rsp_rdata_i(mem_rsp_rdata_i),
    .mem_rsp_error_i(mem_rsp_error_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drv(input logic v, input logic [31:0] a, input logic w);
    slv_req_i = v;
    slv_addr_i = a;
    slv_we_i = w;
    slv_be_i = 4'hF;
    slv_wdata_i = a ^ 32'hA5A5_0000;
  endtask

  task automatic rsp(input logic v, input logic [31:0] d, input logic e);
    mem_rsp_valid_i = v;
    mem_rsp_rdata_i = d;
    mem_rsp_error_i = e;
  endtask

  task automatic chk_rsp(input string tag, input logic v,
                         input logic [31:0] d, input logic e);
    chk({tag, "_v"}, 32'(slv_rvalid_o), 32'(v));
    if (v) begin
      chk({tag, "_d"}, slv_rdata_o, d);
      chk({tag, "_e"}, 32'(slv_err_o), 32'(e));
    end
  endtask

  task automatic wait_rsp(input string tag, input logic [31:0] d,
                          input logic e);
    int n = 0;
    while (!slv_rvalid_o && n < 8) begin
      tick();
      n++;
    end
    chk_rsp(tag, 1'b1, d, e);
    tick();
  endtask

  initial begin
    rst_ni = 1'b0;
    mem_gnt_i = 1'b1;
    drv(1'b0, 32'h0, 1'b0);
    rsp(1'b0, 32'h0, 1'b0);
    #12;
    chk("rst_rvalid", 32'(slv_rvalid_o), 32'h0);
    chk("rst_rdata", slv_rdata_o, 32'h0);
    chk("rst_err", 32'(slv_err_o), 32'h0);
    chk("rst_memreq", 32'(mem_req_o), 32'h0);
    tick();
    rst_ni = 1'b1;
    tick();

    // in-window read, response 3 cycles after grant
    drv(1'b1, 32'h4000_0010, 1'b0);
    #1;
    chk("rd_gnt", 32'(slv_gnt_o), 32'h1);
    chk("rd_req", 32'(mem_req_o), 32'h1);
    chk("rd_addr", mem_addr_o, 32'h0000_0010);
    tick();
    drv(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      chk_rsp("rd_idle", 1'b0, 32'h0, 1'b0);
      tick();
    end
    rsp(1'b1, 32'h1234_5678, 1'b0);
    #1;
    chk_rsp("rd_pre", 1'b0, 32'h0, 1'b0);
    tick();
    rsp(1'b0, 32'h0, 1'b0);
    chk_rsp("rd_rsp", 1'b1, 32'h1234_5678, 1'b0);
    tick();
    chk_rsp("rd_pulse", 1'b0, 32'h0, 1'b0);

    // out-of-window read below base (wrap) and write at window end
    drv(1'b1, 32'h3FFF_FFFC, 1'b0);
    #1;
    chk("oor_gnt", 32'(slv_gnt_o), 32'h1);
    chk("oor_req", 32'(mem_req_o), 32'h0);
    tick();
    drv(1'b1, 32'h5000_0000, 1'b1);
    #1;
    chk("oow_gnt", 32'(slv_gnt_o), 32'h1);
    chk("oow_req", 32'(mem_req_o), 32'h0);
    tick();
    drv(1'b0, 32'h0, 1'b0);
    wait_rsp("oor_rsp", 32'hBADC_AB1E, 1'b1);
    wait_rsp("oow_rsp", 32'h0, 1'b1);

    // ordering: A fwd, B local, C fwd at last window address
    drv(1'b1, 32'h4000_0100, 1'b0);
    #1;
    chk("ordA_gnt", 32'(slv_gnt_o), 32'h1);
    chk("ordA_addr", mem_addr_o, 32'h0000_0100);
    tick();
    drv(1'b1, 32'h0000_1000, 1'b0);
    #1;
    chk("ordB_gnt", 32'(slv_gnt_o), 32'h1);
    chk("ordB_req", 32'(mem_req_o), 32'h0);
    tick();
    drv(1'b1, 32'h4FFF_FFFC, 1'b0);
    #1;
    chk("ordC_gnt", 32'(slv_gnt_o), 32'h1);
    chk("ordC_req", 32'(mem_req_o), 32'h1);
    chk("ordC_addr", mem_addr_o, 32'h0FFF_FFFC);
    tick();
    drv(1'b0, 32'h0, 1'b0);
    chk_rsp("ord_w3", 1'b0, 32'h0, 1'b0);
    tick();
    chk_rsp("ord_w4", 1'b0, 32'h0, 1'b0);
    tick();
    rsp(1'b1, 32'hAAAA_0001, 1'b0);
    chk_rsp("ord_w5", 1'b0, 32'h0, 1'b0);
    tick();
    rsp(1'b1, 32'hCCCC_0003, 1'b0);
    chk_rsp("ord_A", 1'b1, 32'hAAAA_0001, 1'b0);
    tick();
    rsp(1'b0, 32'h0, 1'b0);
    chk_rsp("ord_B", 1'b1, 32'hBADC_AB1E, 1'b1);
    tick();
    chk_rsp("ord_C", 1'b1, 32'hCCCC_0003, 1'b0);
    tick();
    chk_rsp("ord_end", 1'b0, 32'h0, 1'b0);

    // outstanding limit
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 32'h4000_0200 + 32'(4 * i), 1'b0);
      #1;
      chk($sformatf("lim_gnt%0d", i), 32'(slv_gnt_o), 32'h1);
      tick();
    end
    drv(1'b1, 32'h4000_0210, 1'b0);
    #1;
    chk("lim_full_gnt", 32'(slv_gnt_o), 32'h0);
    chk("lim_full_req", 32'(mem_req_o), 32'h0);
    tick();
    rsp(1'b1, 32'hD000_0000, 1'b0);
    #1;
    chk("lim_pop_gnt", 32'(slv_gnt_o), 32'h0);
    tick();
    rsp(1'b0, 32'h0, 1'b0);
    chk("lim_resume_gnt", 32'(slv_gnt_o), 32'h1);
    chk("lim_resume_req", 32'(mem_req_o), 32'h1);
    chk_rsp("lim_r0", 1'b1, 32'hD000_0000, 1'b0);
    tick();
    drv(1'b0, 32'h0, 1'b0);
    for (int i = 1; i < 5; i++) begin
      rsp(1'b1, 32'hD000_0000 + 32'(i), 1'b0);
      tick();
      chk_rsp($sformatf("lim_r%0d", i), 1'b1, 32'hD000_0000 + 32'(i), 1'b0);
    end
    rsp(1'b0, 32'h0, 1'b0);
    tick();
    chk_rsp("lim_end", 1'b0, 32'h0, 1'b0);

    // forwarded write with downstream error, then reset mid-flight
    drv(1'b1, 32'h4000_0300, 1'b1);
    #1;
    chk("wr_gnt", 32'(slv_gnt_o), 32'h1);
    chk("wr_we", 32'(mem_we_o), 32'h1);
    chk("wr_be", 32'(mem_be_o), 32'hF);
    chk("wr_wdata", mem_wdata_o, 32'hE5A5_0300);
    tick();
    drv(1'b1, 32'h4000_0304, 1'b0);
    tick();
    drv(1'b1, 32'h4000_0308, 1'b0);
    rsp(1'b1, 32'hDEAD_0000, 1'b1);
    tick();
    drv(1'b0, 32'h0, 1'b0);
    rsp(1'b0, 32'h0, 1'b0);
    chk_rsp("wr_err", 1'b1, 32'hDEAD_0000, 1'b1);
    chk("pre_rst_cnt", 32'(dut.ord_count), 32'h2);
    rst_ni = 1'b0;
    #1;
    chk("rst2_rvalid", 32'(slv_rvalid_o), 32'h0);
    chk("rst2_rdata", slv_rdata_o, 32'h0);
    chk("rst2_err", 32'(slv_err_o), 32'h0);
    chk("rst2_cnt", 32'(dut.ord_count), 32'h0);
    tick();
    rst_ni = 1'b1;
    tick();
    drv(1'b1, 32'h4000_0400, 1'b0);
    #1;
    chk("post_gnt", 32'(slv_gnt_o), 32'h1);
    chk("post_addr", mem_addr_o, 32'h0000_0400);
    tick();
    drv(1'b0, 32'h0, 1'b0);
    rsp(1'b1, 32'h600D_0001, 1'b0);
    tick();
    rsp(1'b0, 32'h0, 1'b0);
    chk_rsp("post_rsp", 1'b1, 32'h600D_0001, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
